delta_dram_arbiter: RTL and testbench

- Shares the single off-chip DRAM port among the Delta controller managers: weight manager, input manager and output writeback.
- Each manager keeps its existing DRAM_Read / DRAM_Address / DRAM_DataReady style handshake. This block is the only driver of the physical DRAM command port.
- Uses round-robin arbitration, one transaction in flight, with the address and opcode latched at grant.
- Sits between the per-manager FSMs and the DRAM model/controller.

---
 rtl/delta_dram_pkg.sv | 32 +++
 rtl/delta_rr_picker.sv | 42 ++++
 rtl/delta_dram_arbiter.sv | 139 +++++++++++++
 tb/tb_delta_dram_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_dram_pkg.sv
`default_nettype none
//==============================================================================
// Package  : delta_dram_pkg
// Brief    : Shared types and requester IDs for the Delta DRAM port arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package delta_dram_pkg;

    localparam int c_NUM_REQ = 3;

    localparam int REQ_WEIGHT = 0;
    localparam int REQ_INPUT  = 1;
    localparam int REQ_OUTPUT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } dram_op_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delta_rr_picker.sv
`default_nettype none
//==============================================================================
// Module   : delta_rr_picker
// Brief    : Combinational round-robin winner search starting at rr_ptr.
// Revision : 1.0 - initial release
//==============================================================================
module delta_rr_picker
    import delta_dram_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ,
    localparam int IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    int               w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest candidate inwards so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        w_sum  = 0;
        w_cand = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = int'(rr_ptr) + off;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_cand = IDX_W'(w_sum);
            if (req[w_cand]) begin
                valid  = 1'b1;
                winner = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/delta_dram_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : delta_dram_arbiter
// Brief    : Round-robin owner of the single DRAM command port shared by the
//            weight, input and output managers; one transaction in flight.
// Revision : 1.0 - initial release
//==============================================================================
module delta_dram_arbiter
    import delta_dram_pkg::*;
#(
    parameter int NUM_REQ     = c_NUM_REQ,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  Req_Read,
    input  logic [NUM_REQ-1:0]  Req_Write,
    input  logic [ADDR_W-1:0]   Req_Address [NUM_REQ],
    output logic [NUM_REQ-1:0]  Req_Grant,
    output logic [NUM_REQ-1:0]  Req_DataReady,
    output logic [NUM_REQ-1:0]  Req_WriteDone,
    output logic                DRAM_Read,
    output logic                DRAM_Write,
    output logic [ADDR_W-1:0]   DRAM_Address,
    input  logic                DRAM_DataReady,
    input  logic                DRAM_WriteDone,
    output logic                Busy,
    output logic [NUM_REQ-1:0]  Err_Both,
    output logic                Timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] c_IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] c_IDX_FIRST  = IDX_W'(REQ_WEIGHT);
    localparam logic [WD_W-1:0]  c_WDOG_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  c_WDOG_LIMIT = WD_W'(TIMEOUT_CYC);

    arb_state_t         r_state;
    dram_op_t           r_op;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [ADDR_W-1:0]  r_addr;
    logic [WD_W-1:0]    r_wdog;
    logic               r_timeout;
    logic [NUM_REQ-1:0] r_err_both;

    logic [NUM_REQ-1:0] w_req;
    logic               w_valid;
    logic [IDX_W-1:0]   w_winner;
    logic               w_busy;
    logic               w_rd_done;
    logic               w_wr_done;

    assign w_req = Req_Read | Req_Write;

    delta_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (w_req),
        .rr_ptr  (r_rr_ptr),
        .valid   (w_valid),
        .winner  (w_winner)
    );

    assign w_busy    = (r_state == BUSY);
    assign w_rd_done = w_busy && (r_op == READ)  && DRAM_DataReady;
    assign w_wr_done = w_busy && (r_op == WRITE) && DRAM_WriteDone;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_op       <= READ;
            r_rr_ptr   <= c_IDX_FIRST;
            r_gidx     <= c_IDX_FIRST;
            r_addr     <= '0;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
            r_err_both <= '0;
        end else begin
            r_err_both <= r_err_both | (Req_Read & Req_Write);
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gidx  <= w_winner;
                        r_op    <= Req_Read[w_winner] ? READ : WRITE;
                        r_addr  <= Req_Address[w_winner];
                        // The first BUSY cycle already counts towards the limit.
                        r_wdog  <= c_WDOG_ONE;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_rd_done || w_wr_done) begin
                        r_wdog  <= '0;
                        r_state <= RELEASE;
                    end else if (r_wdog < c_WDOG_LIMIT) begin
                        r_wdog <= r_wdog + c_WDOG_ONE;
                        if ((r_wdog + c_WDOG_ONE) == c_WDOG_LIMIT) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    r_rr_ptr <= (r_gidx == c_IDX_LAST) ? '0 : (r_gidx + c_IDX_ONE);
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Response pulses are routed straight through so a manager sees its data
    // in the same cycle the DRAM reports it.
    always_comb begin
        Req_Grant     = '0;
        Req_DataReady = '0;
        Req_WriteDone = '0;
        if (w_busy) begin
            Req_Grant[r_gidx]     = 1'b1;
            Req_DataReady[r_gidx] = w_rd_done;
            Req_WriteDone[r_gidx] = w_wr_done;
        end
    end

    assign DRAM_Read    = w_busy && (r_op == READ);
    assign DRAM_Write   = w_busy && (r_op == WRITE);
    assign DRAM_Address = w_busy ? r_addr : '0;
    assign Busy         = (r_state != IDLE);
    assign Err_Both     = r_err_both;
    assign Timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_delta_dram_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_delta_dram_arbiter
// Brief    : Randomised bench for delta_dram_arbiter against a transaction
//            timeline model of the requesters and the DRAM.
// Revision : 1.0 - initial release
//==============================================================================
module tb_delta_dram_arbiter;

    localparam int c_N   = 3;
    localparam int c_AW  = 32;
    localparam int c_TMO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [c_N-1:0]  Req_Read;
    logic [c_N-1:0]  Req_Write;
    logic [c_AW-1:0] Req_Address [c_N];
    logic [c_N-1:0]  Req_Grant;
    logic [c_N-1:0]  Req_DataReady;
    logic [c_N-1:0]  Req_WriteDone;
    logic            DRAM_Read;
    logic            DRAM_Write;
    logic [c_AW-1:0] DRAM_Address;
    logic            DRAM_DataReady;
    logic            DRAM_WriteDone;
    logic            Busy;
    logic [c_N-1:0]  Err_Both;
    logic            Timeout;

    delta_dram_arbiter #(
        .NUM_REQ        (c_N),
        .ADDR_W         (c_AW),
        .TIMEOUT_CYC    (c_TMO)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .Req_Read       (Req_Read),
        .Req_Write      (Req_Write),
        .Req_Address    (Req_Address),
        .Req_Grant      (Req_Grant),
        .Req_DataReady  (Req_DataReady),
        .Req_WriteDone  (Req_WriteDone),
        .DRAM_Read      (DRAM_Read),
        .DRAM_Write     (DRAM_Write),
        .DRAM_Address   (DRAM_Address),
        .DRAM_DataReady (DRAM_DataReady),
        .DRAM_WriteDone (DRAM_WriteDone),
        .Busy           (Busy),
        .Err_Both       (Err_Both),
        .Timeout        (Timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Requester agents: 0 idle, 1 requesting, 2 served/dropped until release.
    int              st        [c_N];
    bit              want_rd   [c_N];
    bit              want_wr   [c_N];
    logic [c_AW-1:0] want_addr [c_N];

    int p_new, p_wr, p_both, p_drop, p_stray, lat_lo, lat_hi, lat_force;
    bit reset_now, force_dr;

    // Transaction timeline: owner holds the port from cur_start to cur_resp,
    // releases in cur_resp+1, and arbitration may happen again from t_decide.
    int              owner, last_owner, cur_start, cur_resp, t_decide;
    bit              cur_rd;
    logic [c_AW-1:0] cur_addr;
    logic [c_N-1:0]  exp_err;
    bit              exp_to;
    int              grant_log [$];
    int              start_log [$];
    int              resp_log  [$];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        start_log.delete();
        resp_log.delete();
    endtask

    // One clock cycle: drive requesters and DRAM, check outputs, advance model.
    task automatic run_cycle();
        bit             busy_cmd, rel, dr, dw;
        logic [c_N-1:0] lv_rd, lv_wr, exp_grant, exp_dr, exp_wd;
        int             w, lat;
        for (int i = 0; i < c_N; i++) begin
            if (st[i] == 0 && $urandom_range(99) < p_new) begin
                st[i] = 1;
                if ($urandom_range(99) < p_both) begin
                    want_rd[i] = 1'b1;
                    want_wr[i] = 1'b1;
                end else begin
                    want_wr[i] = ($urandom_range(99) < p_wr);
                    want_rd[i] = !want_wr[i];
                end
                want_addr[i] = $urandom;
            end
            lv_rd[i]       = (st[i] == 1) && want_rd[i];
            lv_wr[i]       = (st[i] == 1) && want_wr[i];
            Req_Address[i] = (st[i] == 1) ? want_addr[i] : $urandom;
        end
        busy_cmd = (owner >= 0) && (cyc >= cur_start) && (cyc <= cur_resp);
        rel      = (owner >= 0) && (cyc == cur_resp + 1);
        dr = 1'b0;
        dw = 1'b0;
        if (busy_cmd && cyc == cur_resp) begin
            if (cur_rd) dr = 1'b1;
            else        dw = 1'b1;
        end else if ($urandom_range(99) < p_stray) begin
            if (busy_cmd) begin
                if (cur_rd) dw = 1'b1;
                else        dr = 1'b1;
            end else begin
                dr = ($urandom_range(1) == 1);
                dw = ($urandom_range(1) == 1);
            end
        end
        if (force_dr) dr = 1'b1;
        Req_Read       = lv_rd;
        Req_Write      = lv_wr;
        DRAM_DataReady = dr;
        DRAM_WriteDone = dw;
        reset          = reset_now;

        @(negedge clock);
        if (!reset_now) begin
            if (busy_cmd && (cyc - cur_start + 1) >= c_TMO) exp_to = 1'b1;
            exp_grant = busy_cmd ? (c_N'(1) << owner) : '0;
            exp_dr    = (busy_cmd && cyc == cur_resp && cur_rd)  ? exp_grant : '0;
            exp_wd    = (busy_cmd && cyc == cur_resp && !cur_rd) ? exp_grant : '0;
            check_value("grant",      Req_Grant,     exp_grant);
            check_value("dram_read",  DRAM_Read,     busy_cmd && cur_rd);
            check_value("dram_write", DRAM_Write,    busy_cmd && !cur_rd);
            check_value("dram_addr",  DRAM_Address,  busy_cmd ? cur_addr : '0);
            check_value("data_ready", Req_DataReady, exp_dr);
            check_value("write_done", Req_WriteDone, exp_wd);
            check_value("busy",       Busy,          busy_cmd || rel);
            check_value("err_both",   Err_Both,      exp_err);
            check_value("timeout",    Timeout,       exp_to);
        end

        if (reset_now) begin
            owner      = -1;
            last_owner = c_N - 1;
            t_decide   = cyc + 1;
            exp_err    = '0;
            exp_to     = 1'b0;
            for (int i = 0; i < c_N; i++) st[i] = 0;
        end else begin
            exp_err = exp_err | (lv_rd & lv_wr);
            if (busy_cmd && cyc == cur_resp) begin
                st[owner] = 2;
                resp_log.push_back(cyc);
            end else if (busy_cmd && $urandom_range(99) < p_drop) begin
                st[owner] = 2;
            end
            if (rel) begin
                st[owner]  = 0;
                last_owner = owner;
                owner      = -1;
                t_decide   = cyc + 1;
            end else if (owner < 0 && cyc >= t_decide && (lv_rd | lv_wr) != '0) begin
                w = -1;
                for (int k = 1; k <= c_N; k++) begin
                    if (w < 0 && (lv_rd[(last_owner + k) % c_N] || lv_wr[(last_owner + k) % c_N]))
                        w = (last_owner + k) % c_N;
                end
                lat       = (lat_force >= 0) ? lat_force : int'($urandom_range(lat_hi, lat_lo));
                owner     = w;
                cur_rd    = lv_rd[w];
                cur_addr  = Req_Address[w];
                cur_start = cyc + 1;
                cur_resp  = cur_start + lat;
                grant_log.push_back(w);
                start_log.push_back(cur_start);
            end
        end
        reset_now = 1'b0;
        force_dr  = 1'b0;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic set_knobs(input int pn, input int pw, input int pb, input int pd,
                             input int ps, input int lf);
        p_new = pn; p_wr = pw; p_both = pb; p_drop = pd; p_stray = ps; lat_force = lf;
    endtask

    task automatic request(input int i, input bit rd, input bit wr, input logic [c_AW-1:0] a);
        st[i] = 1; want_rd[i] = rd; want_wr[i] = wr; want_addr[i] = a;
    endtask

    function automatic bit agents_idle();
        bit idle = (owner < 0);
        for (int i = 0; i < c_N; i++) if (st[i] != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (!agents_idle() && k < budget) begin
            run_cycle();
            k++;
        end
        check_value(tag, (k < budget), 1'b1);
    endtask

    task automatic pulse_reset();
        reset_now = 1'b1;
        run_cycle();
    endtask

    initial begin
        int base, k;
        reset = 1'b1;
        Req_Read = '0; Req_Write = '0; DRAM_DataReady = 1'b0; DRAM_WriteDone = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            Req_Address[i] = '0; st[i] = 0; want_rd[i] = 0; want_wr[i] = 0; want_addr[i] = '0;
        end
        set_knobs(0, 0, 0, 0, 0, -1);
        lat_lo = 0; lat_hi = 5; reset_now = 0; force_dr = 0;
        owner = -1; last_owner = c_N - 1; t_decide = 0; cur_start = 0; cur_resp = 0;
        cur_rd = 0; cur_addr = '0; exp_err = '0; exp_to = 0;

        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        check_value("rst_grant", Req_Grant, 0);
        check_value("rst_dr",    Req_DataReady, 0);
        check_value("rst_wd",    Req_WriteDone, 0);
        check_value("rst_cmd",   {DRAM_Read, DRAM_Write}, 0);
        check_value("rst_addr",  DRAM_Address, 0);
        check_value("rst_busy",  Busy, 0);
        check_value("rst_err",   Err_Both, 0);
        check_value("rst_to",    Timeout, 0);
        @(posedge clock); #1;

        // Single read of 0x100, DRAM answering in cycle 5.
        clear_logs();
        base = cyc;
        set_knobs(0, 0, 0, 0, 0, 4);
        request(0, 1'b1, 1'b0, 32'h100);
        for (int i = 0; i < 8; i++) run_cycle();
        check_value("single_owner", grant_log[0], 0);
        check_value("single_cmd",   start_log[0] - base, 1);
        check_value("single_resp",  resp_log[0] - base, 5);

        // Round-robin with everybody reading back-to-back, latency 3.
        set_knobs(0, 0, 0, 0, 0, 3);
        pulse_reset();
        clear_logs();
        set_knobs(100, 0, 0, 0, 0, 3);
        k = 0;
        while (resp_log.size() < 6 && k < 100) begin run_cycle(); k++; end
        check_value("rr_budget", (k < 100), 1'b1);
        set_knobs(0, 0, 0, 0, 0, 3);
        wait_idle("rr_drain", 60);
        for (int i = 0; i < 6; i++) check_value("rr_order", grant_log[i], i % c_N);
        for (int i = 1; i < 6; i++) begin
            // Arbitration happens in the IDLE cycle, one before the command.
            check_value("rr_gap", (start_log[i] - 1) - resp_log[i-1], 2);
            check_value("rr_repeat", (grant_log[i] != grant_log[i-1]), 1'b1);
        end

        // Pointer wrap: a lone write from 2, then 0 and 1 read together.
        pulse_reset();
        clear_logs();
        set_knobs(0, 0, 0, 0, 50, 2);
        request(2, 1'b0, 1'b1, $urandom);
        k = 0;
        while (!(resp_log.size() >= 1 && owner < 0) && k < 30) begin run_cycle(); k++; end
        check_value("wrap_budget", (k < 30), 1'b1);
        request(0, 1'b1, 1'b0, $urandom);
        request(1, 1'b1, 1'b0, $urandom);
        wait_idle("wrap_drain", 60);
        check_value("wrap_first",  grant_log[0], 2);
        check_value("wrap_second", grant_log[1], 0);
        check_value("wrap_third",  grant_log[2], 1);

        // Both bits from requester 1, with stray WriteDone during the read.
        pulse_reset();
        clear_logs();
        set_knobs(0, 0, 0, 0, 100, 3);
        request(1, 1'b1, 1'b1, $urandom);
        wait_idle("both_drain", 30);
        check_value("both_owner", grant_log[0], 1);
        check_value("both_err", Err_Both, 3'b010);
        set_knobs(0, 0, 0, 0, 0, -1);
        for (int i = 0; i < 10; i++) run_cycle();
        check_value("both_sticky", Err_Both, 3'b010);

        // Reset in the second BUSY cycle, then a late DataReady.
        clear_logs();
        set_knobs(0, 0, 0, 0, 0, 6);
        request(2, 1'b1, 1'b0, $urandom);
        k = 0;
        while (!(owner >= 0 && cyc == cur_start + 1) && k < 20) begin run_cycle(); k++; end
        check_value("rstmid_budget", (k < 20), 1'b1);
        pulse_reset();
        clear_logs();
        set_knobs(100, 0, 0, 0, 0, 2);
        force_dr = 1'b1;
        run_cycle();
        check_value("rstmid_prio", grant_log[0], 0);
        set_knobs(0, 0, 0, 0, 0, 2);
        wait_idle("rstmid_drain", 60);

        // Random traffic.
        set_knobs(30, 40, 5, 10, 20, -1);
        for (int i = 0; i < 1500; i++) run_cycle();
        set_knobs(0, 40, 0, 0, 20, -1);
        wait_idle("rand_drain", 200);

        // Watchdog: 20 cycles without a response, then a late DataReady.
        clear_logs();
        set_knobs(0, 0, 0, 0, 0, 20);
        request(0, 1'b1, 1'b0, $urandom);
        wait_idle("to_drain", 40);
        check_value("to_len",   resp_log[0] - start_log[0], 20);
        check_value("to_stick", Timeout, 1'b1);
        check_value("to_idle",  Busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
